fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that feeds the instruction decoder. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It latches each returned word into an instruction register (IR) that drives the decoder's instruction input, and presents it to the next stage with a valid/ready handshake. It also handles control-flow redirects and halt.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch word address
imem_ack  in  1  memory has accepted the request and imem_rdata is valid this cycle
imem_rdata  in  32  fetched instruction word
ir_valid  out  1  IR holds a valid instruction
ir_data  out  32  IR contents, wired to decoder instruction input
ir_pc  out  32  address of the instruction in IR
ir_ready  in  1  downstream accepts IR this cycle
redirect_valid  in  1  branch/jump/trap redirect request
redirect_pc  in  32  redirect target
halt  in  1  stop issuing new fetches

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous and active-low.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir_valid=0, ir_data=32'h0000_0013 (NOP), ir_pc=RESET_PC.
- Reset mid-transaction: takes priority over everything; any outstanding fetch is abandoned and a late imem_ack is ignored.
- All outputs are registered.
- States: IDLE, REQ, HAND, DRAIN.
- IDLE: imem_req=0. Moves to REQ on the first cycle halt=0, so the first request goes out one cycle after reset release.
- REQ:
  - imem_req=1; imem_addr=pc held stable until imem_ack.
  - On imem_ack: ir_data<=imem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+4, state->HAND.
  - imem_req drops the cycle after ack.
  - Ack may arrive in the first req cycle (zero-wait).
- HAND: ir_valid=1; ir_data and ir_pc held stable while ir_ready=0. On ir_ready: ir_valid<=0; state->IDLE if halt=1, else ->REQ.
- Throughput: at most one instruction per 2 cycles with zero-wait memory.
- imem_ack while imem_req=0 is ignored.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect: highest priority after reset.
  - pc<=redirect_pc with bits [1:0] forced to 0; ir_valid<=0 next cycle, so any IR content is dropped even if ir_ready=1 that cycle.
  - In REQ without ack: state->DRAIN. The req/ack protocol forbids withdrawing a request.
  - In REQ with ack in the same cycle: returned data is discarded; state->REQ with the new pc.
  - In HAND or IDLE: state->REQ, or IDLE if halt=1.
- DRAIN: imem_req=1, old imem_addr held. On ack, data is discarded; state->REQ, which fetches the redirect pc. A further redirect in DRAIN only updates pc.
- halt affects only the IDLE/REQ decision at HAND exit and at IDLE. A fetch in progress always completes.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0 and wrapping modulo 2^32.
  - perf_fetched increments each cycle with ir_valid&ir_ready&!redirect_valid.
  - perf_stall increments each cycle with imem_req=1 and imem_ack=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=32'h100, halt=0, zero-wait memory returning addr-based words, ir_ready=1 -> imem_addr sequence 100,104,108; ir_pc matches; ir_valid pulses every 2nd cycle.
- Memory ack delayed 3 cycles, ir_ready=0 for 4 cycles -> imem_addr stable during wait; ir_data/ir_pc stable until ir_ready; no new req while in HAND.
- Redirect to 32'h203 during REQ with pending req, ack 2 cycles later -> stale data discarded (ir_valid stays 0); next req at 32'h200; ir_pc=32'h200.
- Redirect asserted in the same cycle as ack, and separately during HAND with ir_ready=1 -> no IR handed over; next fetch at the target.
- PC=32'hFFFF_FFFC fetch -> next imem_addr=0; halt=1 during HAND -> after accept, imem_req stays 0 until halt=0.
- With FETCH_PERF_EN, 5 instructions, memory stalls 2 cycles each -> perf_fetched=5, perf_stall=10; reset mid-run clears both to 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches words over req/ack, hands them to decode via IR.
// Optional build macro FETCH_PERF_EN adds perf_fetched/perf_stall counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   output logic [31:0] ir_data,
   output logic [31:0] ir_pc,
   input  logic        ir_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, REQ, HAND, DRAIN} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] addr_n, ir_data_n, ir_pc_n;
   logic        req_n, ir_valid_n;
   logic        ack;

   // an ack with no request outstanding is noise and must not move anything
   assign ack = imem_ack & imem_req;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (!halt) state_n = REQ;
         REQ: begin
            // a request already on the bus cannot be withdrawn, so drain it
            if (redirect_valid) state_n = ack ? REQ : DRAIN;
            else if (ack)       state_n = HAND;
         end
         HAND:  if (redirect_valid || ir_ready) state_n = halt ? IDLE : REQ;
         DRAIN: if (ack) state_n = REQ;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      pc_n       = pc;
      ir_valid_n = ir_valid;
      ir_data_n  = ir_data;
      ir_pc_n    = ir_pc;
      if (state == REQ && ack && !redirect_valid) begin
         ir_data_n  = imem_rdata;
         ir_pc_n    = pc;
         ir_valid_n = 1'b1;
         pc_n       = pc + 32'd4;
      end
      if (state == HAND && ir_ready) ir_valid_n = 1'b0;
      if (redirect_valid) begin
         pc_n       = {redirect_pc[31:2], 2'b00};
         ir_valid_n = 1'b0;
      end
      req_n  = (state_n == REQ) || (state_n == DRAIN);
      // while draining, the bus must keep showing the abandoned address
      addr_n = (state_n == DRAIN) ? imem_addr : pc_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         ir_valid  <= 1'b0;
         ir_data   <= NOP;
         ir_pc     <= RESET_PC;
      end else begin
         pc        <= pc_n;
         imem_req  <= req_n;
         imem_addr <= addr_n;
         ir_valid  <= ir_valid_n;
         ir_data   <= ir_data_n;
         ir_pc     <= ir_pc_n;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         if (ir_valid && ir_ready && !redirect_valid) perf_fetched <= perf_fetched + 32'd1;
         if (imem_req && !imem_ack)                   perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: transaction-level model checked every cycle plus literal pins.
module tb_fetch_ctrl;

   localparam logic [31:0] RST = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, imem_req, imem_ack, ir_valid, ir_ready, redirect_valid, halt;
   logic [31:0] imem_addr, imem_rdata, ir_data, ir_pc, redirect_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_stall;
   logic [31:0] m_pf, m_ps;
`endif

   int checks = 0, failures = 0;
   int lat = 0, cnt = 0;
   logic spur = 1'b0;

   // model: one fetch outstanding or not, whether it is stale, and IR contents
   logic        mvalid = 1'b0;
   logic        m_out, m_stale, m_irv, acc_t, had_t;
   logic [31:0] m_pc, m_addr, m_ird, m_irpc;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RST)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         mvalid = 1'b1;
         m_pc = RST; m_out = 1'b0; m_addr = RST; m_stale = 1'b0;
         m_irv = 1'b0; m_ird = NOP; m_irpc = RST;
`ifdef FETCH_PERF_EN
         m_pf = 0; m_ps = 0;
`endif
      end else if (mvalid) begin
         acc_t = m_out && imem_ack;
         had_t = m_irv;
`ifdef FETCH_PERF_EN
         if (had_t && ir_ready && !redirect_valid) m_pf = m_pf + 1;
         if (m_out && !imem_ack) m_ps = m_ps + 1;
`endif
         if (acc_t && !m_stale && !redirect_valid) begin
            m_ird = imem_rdata; m_irpc = m_addr; m_irv = 1'b1; m_pc = m_addr + 32'd4;
         end else if (had_t && ir_ready) m_irv = 1'b0;
         if (redirect_valid) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_irv = 1'b0;
         end
         if (m_out) begin
            if (acc_t) begin
               m_out = m_stale || redirect_valid; m_stale = 1'b0; m_addr = m_pc;
            end else m_stale = m_stale || redirect_valid;
         end else if (!had_t || ir_ready || redirect_valid) begin
            m_out = !halt; m_addr = m_pc; m_stale = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("imem_req", {31'd0, imem_req}, {31'd0, m_out});
         if (m_out) chk("imem_addr", imem_addr, m_addr);
         chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_irv});
         chk("ir_data", ir_data, m_ird);
         chk("ir_pc", ir_pc, m_irpc);
`ifdef FETCH_PERF_EN
         chk("perf_fetched", perf_fetched, m_pf);
         chk("perf_stall", perf_stall, m_ps);
`endif
      end
   end

   // advance one cycle and play memory: ack after `lat` waiting cycles
   task automatic tick();
      logic took, busy;
      took = imem_req && imem_ack;
      busy = imem_req;
      @(posedge clk); #1;
      if (!rst_n || took) cnt = 0;
      else if (busy) cnt++;
      imem_ack   = (imem_req && cnt >= lat) || spur;
      imem_rdata = imem_addr ^ 32'hDEAD_0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; halt = 1'b0; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;

      // reset state
      do_reset();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h100);
      chk("rst_irv", {31'd0, ir_valid}, 32'd0);
      chk("rst_ird", ir_data, 32'h13);
      chk("rst_irpc", ir_pc, 32'h100);

      // zero-wait streaming
      tick();
      chk("s1_req", {31'd0, imem_req}, 32'd1);
      chk("s1_addr0", imem_addr, 32'h100);
      tick();
      chk("s1_irv0", {31'd0, ir_valid}, 32'd1);
      chk("s1_irpc0", ir_pc, 32'h100);
      chk("s1_ird0", ir_data, 32'hDEAD_0100);
      tick();
      chk("s1_addr1", imem_addr, 32'h104);
      chk("s1_irv_gap", {31'd0, ir_valid}, 32'd0);
      tick();
      chk("s1_irpc1", ir_pc, 32'h104);
      tick();
      chk("s1_addr2", imem_addr, 32'h108);

      // slow memory, stalled consumer
      lat = 3; ir_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("s2_addr_hold", imem_addr, 32'h100);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("s2_irpc_hold", ir_pc, 32'h100);
         chk("s2_no_req", {31'd0, imem_req}, 32'd0);
         tick();
      end
      ir_ready = 1'b1;
      tick();
      chk("s2_next_addr", imem_addr, 32'h104);

      // redirect with a pending request
      lat = 2;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      chk("s3_stale_irv", {31'd0, ir_valid}, 32'd0);
      chk("s3_new_addr", imem_addr, 32'h200);
      tick(); tick(); tick();
      chk("s3_irpc", ir_pc, 32'h200);

      // redirect coinciding with ack, then during HAND with ir_ready=1
      lat = 0;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect_valid = 1'b0;
      chk("s4_ack_redir_irv", {31'd0, ir_valid}, 32'd0);
      chk("s4_ack_redir_addr", imem_addr, 32'h300);
      tick();
      chk("s4_irpc300", ir_pc, 32'h300);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("s4_hand_redir_irv", {31'd0, ir_valid}, 32'd0);
      chk("s4_hand_redir_addr", imem_addr, 32'hFFFF_FFFC);

      // PC wrap, then halt during HAND with a spurious ack while idle
      tick();
      chk("s5_irpc_top", ir_pc, 32'hFFFF_FFFC);
      tick();
      chk("s5_wrap_addr", imem_addr, 32'h0);
      tick();
      halt = 1'b1;
      tick();
      spur = 1'b1;
      tick();
      spur = 1'b0;
      tick(); tick();
      chk("s5_halt_req", {31'd0, imem_req}, 32'd0);
      chk("s5_spur_irpc", ir_pc, 32'h0);
      halt = 1'b0;
      tick();
      chk("s5_resume_addr", imem_addr, 32'h4);
      tick(); tick();

`ifdef FETCH_PERF_EN
      begin
         int n = 0, guard = 0;
         lat = 2;
         do_reset();
         while (n < 5 && guard < 200) begin
            if (ir_valid && n == 4) halt = 1'b1;
            if (ir_valid && ir_ready) n++;
            tick();
            guard++;
         end
         if (n < 5) chk("perf_timeout", 32'(n), 32'd5);
         tick(); tick();
         chk("perf_fetched5", perf_fetched, 32'd5);
         chk("perf_stall10", perf_stall, 32'd10);
         halt = 1'b0;
         tick(); tick();
         do_reset();
         chk("perf_rst_f", perf_fetched, 32'd0);
         chk("perf_rst_s", perf_stall, 32'd0);
      end
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
